// File: rtl/fifo_pkg.sv
// Shared definitions for the switch-path buffers: read-mode selectors and
// the address-width helper used to size pointers and storage.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// Handshake/data bundle between a FIFO producer/consumer (master) and the
// fifo_flex buffer (slave).
interface fifo_flex_if
  import fifo_pkg::*;
#(
  parameter int W_WIDTH    = 8,
  parameter int FIFO_DEPTH = 64
) ();

  localparam int AW = fifo_addr_width(FIFO_DEPTH);

  logic               flush;
  logic               wr_en;
  logic [W_WIDTH-1:0] data_in;
  logic               rd_en;
  logic [W_WIDTH-1:0] data_out;
  logic               rd_valid;
  logic               empty;
  logic               full;
  logic               almost_empty;
  logic               almost_full;
  logic [AW:0]        level;
  logic               overflow;
  logic               underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, empty, full, almost_empty, almost_full,
           level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, empty, full, almost_empty, almost_full,
           level, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are defined only by the owner's pointers.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int W_WIDTH    = 8,
  parameter int FIFO_DEPTH = 64,
  localparam int AW        = fifo_addr_width(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [W_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [W_WIDTH-1:0] o_rd_data
);

  logic [W_WIDTH-1:0] r_mem [FIFO_DEPTH];

  // NOTE: storage has no reset; pointers alone decide which words are valid,
  // so clearing the array would only add fan-out on rst_n.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with standard or first-word-fall-through read,
// fill level, almost thresholds, synchronous flush and overflow/underflow pulses.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int W_WIDTH    = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_LEVEL   = FIFO_DEPTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  fifo_flex_if.slave bus
);

  localparam int          AW      = fifo_addr_width(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_LEVEL);

  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (AE_LEVEL >= AF_LEVEL)) begin : g_bad_cfg
    $fatal(1, "fifo_flex: FIFO_DEPTH must be a power of two >= 4 and AE_LEVEL < AF_LEVEL");
  end

  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic               r_overflow;
  logic               r_underflow;
  logic [AW:0]        w_level;
  logic               w_empty;
  logic               w_full;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic [W_WIDTH-1:0] w_mem_rd;

  // Flags come from registered pointers only; the extra wrap bit makes
  // the modular difference span 0..FIFO_DEPTH.
  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (w_level == '0);
  assign w_full   = (w_level == DEPTH_L);
  assign w_wr_acc = bus.wr_en && !w_full && !bus.flush;
  assign w_rd_acc = bus.rd_en && !w_empty && !bus.flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overflow  <= bus.wr_en && w_full;
      r_underflow <= bus.rd_en && w_empty;
    end
  end

  fifo_mem #(
    .W_WIDTH    (W_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (bus.data_in),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_mem_rd)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign bus.data_out = w_empty ? '0 : w_mem_rd;
    assign bus.rd_valid = !w_empty;
  end else begin : g_std
    logic [W_WIDTH-1:0] r_data_out;
    logic               r_rd_valid;

    // data_out deliberately holds across idle cycles and flush.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data_out <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc) r_data_out <= w_mem_rd;
      end
    end

    assign bus.data_out = r_data_out;
    assign bus.rd_valid = r_rd_valid;
  end

  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (w_level <= AE_L);
  assign bus.almost_full  = (w_level >= AF_L);
  assign bus.level        = w_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex at depth 8: a standard-mode and an FWFT instance,
// table-driven fill/overflow vectors plus scoreboard-checked sequences.
module tb_fifo_flex;
  import fifo_pkg::*;

  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_flex_if #(.W_WIDTH(8), .FIFO_DEPTH(DEPTH)) s_if ();
  fifo_flex_if #(.W_WIDTH(8), .FIFO_DEPTH(DEPTH)) f_if ();

  fifo_flex #(
    .W_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(FIFO_MODE_STD), .AF_LEVEL(4), .AE_LEVEL(1)
  ) u_std (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));

  fifo_flex #(
    .W_WIDTH(8), .FIFO_DEPTH(DEPTH), .FWFT(FIFO_MODE_FWFT), .AF_LEVEL(4), .AE_LEVEL(1)
  ) u_fwft (.clk(clk), .rst_n(rst_n), .bus(f_if.slave));

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [3:0] lvl;
    logic       full;
    logic       empty;
    logic       af;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t       vecs [12];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb [$];
  int         m_lvl   = 0;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " s.data_out"}, 32'(s_if.data_out), 0);
    check({tag, " s.rd_valid"}, 32'(s_if.rd_valid), 0);
    check({tag, " s.empty"},    32'(s_if.empty), 1);
    check({tag, " s.full"},     32'(s_if.full), 0);
    check({tag, " s.ae"},       32'(s_if.almost_empty), 1);
    check({tag, " s.af"},       32'(s_if.almost_full), 0);
    check({tag, " s.level"},    32'(s_if.level), 0);
    check({tag, " s.ovf"},      32'(s_if.overflow), 0);
    check({tag, " s.unf"},      32'(s_if.underflow), 0);
    check({tag, " f.data_out"}, 32'(f_if.data_out), 0);
    check({tag, " f.rd_valid"}, 32'(f_if.rd_valid), 0);
    check({tag, " f.empty"},    32'(f_if.empty), 1);
    check({tag, " f.level"},    32'(f_if.level), 0);
  endtask

  task automatic check_std_flags(input string tag);
    check({tag, " level"},    32'(s_if.level), 32'(m_lvl));
    check({tag, " empty"},    32'(s_if.empty), 32'(m_lvl == 0));
    check({tag, " full"},     32'(s_if.full), 32'(m_lvl == DEPTH));
    check({tag, " ae"},       32'(s_if.almost_empty), 32'(m_lvl <= 1));
    check({tag, " af"},       32'(s_if.almost_full), 32'(m_lvl >= 4));
    check({tag, " data_out"}, 32'(s_if.data_out), 32'(last_rd));
  endtask

  // One clock of standard-mode traffic; the model decides acceptance and the
  // scoreboard supplies the word each accepted read must return.
  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd);
    logic acc_w, acc_r;
    s_if.wr_en   = wr;
    s_if.data_in = d;
    s_if.rd_en   = rd;
    acc_w = wr && (m_lvl != DEPTH);
    acc_r = rd && (m_lvl != 0);
    if (acc_w) sb.push_back(d);
    if (acc_r) last_rd = sb.pop_front();
    m_lvl = m_lvl + int'(acc_w) - int'(acc_r);
    tick();
    s_if.wr_en = 1'b0;
    s_if.rd_en = 1'b0;
    check("std rd_valid",  32'(s_if.rd_valid), 32'(acc_r));
    check("std overflow",  32'(s_if.overflow), 32'(wr && !acc_w));
    check("std underflow", 32'(s_if.underflow), 32'(rd && !acc_r));
    check_std_flags("std");
  endtask

  task automatic model_clear();
    m_lvl = 0;
    sb.delete();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++)
      vecs[2+k] = '{1'b1, 1'b0, 8'(k + 1), 4'(k + 1), 1'(k == 7), 1'b0,
                    1'((k + 1) >= 4), 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h99, 4'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    {s_if.flush, s_if.wr_en, s_if.rd_en, s_if.data_in} = '0;
    {f_if.flush, f_if.wr_en, f_if.rd_en, f_if.data_in} = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check_reset("reset");

    // Underflow, fill to full, overflow attempt.
    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].wr, vecs[i].din, vecs[i].rd);
      check($sformatf("vec%0d level", i), 32'(s_if.level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d full", i),  32'(s_if.full), 32'(vecs[i].full));
      check($sformatf("vec%0d empty", i), 32'(s_if.empty), 32'(vecs[i].empty));
      check($sformatf("vec%0d af", i),    32'(s_if.almost_full), 32'(vecs[i].af));
      check($sformatf("vec%0d ovf", i),   32'(s_if.overflow), 32'(vecs[i].ovf));
      check($sformatf("vec%0d unf", i),   32'(s_if.underflow), 32'(vecs[i].unf));
    end

    // Drain: words come back 0x01..0x08, one cycle after each rd_en.
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check("drain order", 32'(s_if.data_out), 32'(k + 1));
    end
    cyc(1'b0, 8'h00, 1'b0);

    // Wrap-around across address 7 -> 0.
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h10 + k), 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++) cyc(1'b1, 8'(8'h20 + k), 1'b0);
    check("wrap full", 32'(s_if.full), 1);
    for (int k = 0; k < 8; k++) cyc(1'b0, 8'h00, 1'b1);
    check("wrap empty", 32'(s_if.empty), 1);
    check("wrap last word", 32'(s_if.data_out), 32'h27);

    // Simultaneous read+write at level 3, then at full.
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h30 + k), 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 8'(8'h40 + k), 1'b1);
    check("simul level3", 32'(s_if.level), 3);
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h50 + k), 1'b0);
    check("simul full", 32'(s_if.full), 1);
    cyc(1'b1, 8'hEE, 1'b1);
    check("full wr+rd level", 32'(s_if.level), 7);
    check("full wr+rd ovf", 32'(s_if.overflow), 1);
    for (int k = 0; k < 7; k++) cyc(1'b0, 8'h00, 1'b1);

    // FWFT: head word visible without rd_en, pop empties.
    f_if.wr_en = 1'b1; f_if.data_in = 8'hA5;
    tick();
    f_if.wr_en = 1'b0;
    check("fwft head", 32'(f_if.data_out), 32'hA5);
    check("fwft rd_valid", 32'(f_if.rd_valid), 1);
    check("fwft empty", 32'(f_if.empty), 0);
    tick();
    check("fwft hold head", 32'(f_if.data_out), 32'hA5);
    f_if.rd_en = 1'b1;
    tick();
    f_if.rd_en = 1'b0;
    check("fwft pop empty", 32'(f_if.empty), 1);
    check("fwft pop data", 32'(f_if.data_out), 0);
    check("fwft pop rd_valid", 32'(f_if.rd_valid), 0);
    f_if.wr_en = 1'b1; f_if.data_in = 8'hB1; tick();
    f_if.data_in = 8'hB2; tick();
    f_if.wr_en = 1'b0;
    check("fwft level2", 32'(f_if.level), 2);
    check("fwft head B1", 32'(f_if.data_out), 32'hB1);
    f_if.rd_en = 1'b1; tick();
    check("fwft head B2", 32'(f_if.data_out), 32'hB2);
    tick();
    check("fwft drained", 32'(f_if.empty), 1);
    tick();
    f_if.rd_en = 1'b0;
    check("fwft underflow", 32'(f_if.underflow), 1);

    // Flush at level 5 with a concurrent write.
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h60 + k), 1'b0);
    s_if.flush = 1'b1; s_if.wr_en = 1'b1; s_if.data_in = 8'hF0;
    tick();
    s_if.flush = 1'b0; s_if.wr_en = 1'b0;
    model_clear();
    check("flush rd_valid", 32'(s_if.rd_valid), 0);
    check("flush ovf", 32'(s_if.overflow), 0);
    check_std_flags("flush");
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("post-flush word", 32'(s_if.data_out), 32'h77);

    // Asynchronous reset in the middle of a burst.
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h80 + k), 1'b0);
    s_if.wr_en = 1'b1; s_if.data_in = 8'h90;
    f_if.wr_en = 1'b1; f_if.data_in = 8'h91;
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset("async reset");
    s_if.wr_en = 1'b0; f_if.wr_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
    last_rd = 8'h00;
    tick();
    check_reset("after reset");
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    check("post-reset word", 32'(s_if.data_out), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
# fifo_flex

Parametrised synchronous FIFO, the next-generation buffer for the unit address decoder's per-switch ingress/egress paths. Generalises the existing fixed-behaviour FIFO with configurable width/depth, a selectable standard or first-word-fall-through (FWFT) read mode, fill-level reporting, almost-full/almost-empty thresholds, synchronous flush and overflow/underflow error pulses. Data words are never cleared on read; only pointers define contents.

## Interface
Parameters:
- W_WIDTH, 8, data word width in bits (≥1)
- FIFO_DEPTH, 64, number of entries; power of two, ≥4
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
- AF_LEVEL, FIFO_DEPTH-4, almost_full asserted when level ≥ AF_LEVEL
- AE_LEVEL, 4, almost_empty asserted when level ≤ AE_LEVEL

Ports (AW = $clog2(FIFO_DEPTH)):
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of pointers and flags
- wr_en  in  1  write request
- data_in  in  W_WIDTH  write data
- rd_en  in  1  read request (standard) / pop (FWFT)
- data_out  out  W_WIDTH  read data
- rd_valid  out  1  data_out holds a valid popped/head word
- empty  out  1  level == 0
- full  out  1  level == FIFO_DEPTH
- almost_empty  out  1  level ≤ AE_LEVEL
- almost_full  out  1  level ≥ AF_LEVEL
- level  out  AW+1  current entry count, 0..FIFO_DEPTH
- overflow  out  1  one-cycle pulse: write attempted while full
- underflow  out  1  one-cycle pulse: read attempted while empty

## Operation
- Pointers wr_ptr/rd_ptr are AW+1 bits (extra wrap bit); address = low AW bits; wrap from DEPTH-1 to 0 is natural modular increment. level = wr_ptr − rd_ptr (AW+1-bit modular).
- Write accepted iff wr_en && !full (full = registered state at the edge); stores data_in at wr_ptr, increments wr_ptr.
- Read accepted iff rd_en && !empty; increments rd_ptr.
- Full state blocks writes even if a read is accepted the same cycle. Empty state blocks reads even if a write is accepted the same cycle. Otherwise simultaneous accepted read+write leaves level unchanged.
- Standard mode: on accepted read, data_out <= mem[rd_ptr], rd_valid = 1 for the next cycle; with no accepted read rd_valid = 0 and data_out holds its last value.
- FWFT mode: data_out = mem[rd_ptr] combinationally when !empty, 0 when empty; rd_valid = !empty; rd_en consumes the presented word.
- overflow = registered (wr_en && full); underflow = registered (rd_en && empty).
- flush: priority over wr_en/rd_en; pointers to 0, rd_valid 0, overflow/underflow 0; memory contents untouched; standard-mode data_out holds.
- Reset: data_out 0, rd_valid 0, empty 1, full 0, almost_empty 1, almost_full 0, level 0, overflow 0, underflow 0. Reset mid-operation discards all contents.

## Timing
- Write-to-flag latency: empty/level/almost_* reflect a write one cycle after the accepting edge.
- Standard read latency: 1 cycle (data_out/rd_valid valid after edge where rd_en accepted).
- FWFT: first word visible on data_out the cycle after its write edge (empty falls).
- Throughput: one write and one read per cycle, sustained.
- Flags derived combinationally from registered pointers only; no combinational path from wr_en/rd_en to any output except FWFT data_out via rd_ptr (registered).

## Structure
- Shared package fifo_pkg: read-mode constants (FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1) and a function computing AW from depth; reused by other buffers in the switch path.
- Sub-module fifo_mem: simple dual-port register array (one write port, one async read port, W_WIDTH × FIFO_DEPTH, no reset on storage). Pointer/flag logic stays in fifo_flex.
- Elaboration check: fatal if FIFO_DEPTH not a power of two or AE_LEVEL ≥ AF_LEVEL.

## Test plan
- Reset then idle: all outputs at reset values; rd_en pulse while empty -> underflow=1 for one cycle, rd_valid=0, level=0.
- DEPTH=8 std: write 0x01..0x08 -> full=1, level=8, almost_full=1 from level 4; 9th write -> overflow pulse, contents unchanged; read 8 -> 0x01..0x08 in order, each 1 cycle after rd_en.
- Wrap-around: 3 writes/3 reads, then 8 writes/8 reads -> correct order across address 7->0, full/empty at exact boundaries.
- Simultaneous: at level 3 wr_en+rd_en for 10 cycles -> level stays 3, stream in order; at full wr+rd -> read accepted, write dropped with overflow, level 7.
- FWFT=1: write 0xA5 -> next cycle data_out=0xA5, rd_valid=1 without rd_en; rd_en -> empty=1, data_out=0.
- flush at level 5 with concurrent wr_en -> level 0, empty=1, write ignored; rst_n low mid-burst -> immediate return to reset values.
